// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID->EX hazard scoreboard: forwarding-mux
// select encodings and pipeline depth.
package hazard_scoreboard_pkg;

    // EX operand mux selects
    localparam logic [1:0] FWD_RF        = 2'd0;  // register file read
    localparam logic [1:0] FWD_EXMEM     = 2'd1;  // EX/Mem ALUout
    localparam logic [1:0] FWD_MEMWR_ALU = 2'd2;  // Mem/Wr ALUout
    localparam logic [1:0] FWD_MEMWR_LD  = 2'd3;  // Mem/Wr DataOut

    // IF/ID/EX/Mem/Wr
    localparam int unsigned PIPE_STAGES = 5;

endpackage : hazard_scoreboard_pkg

// File: rtl/hazard_scoreboard_operand_classify.sv
// Classifies one source operand against its scoreboard entry.
// Ports:
//   c      - remaining cycles until the producer's result is in the RF
//   ld     - producer is a load
//   used   - instruction actually reads this operand
//   idx    - operand register index
//   fwd    - forwarding select for the EX operand mux
//   hazard - operand cannot be satisfied this cycle
module operand_classify
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned WB_LAT      = 3,
    parameter int unsigned RF_WR_FIRST = 1,
    parameter int unsigned CW          = 2,
    parameter int unsigned REG_AW      = 5
) (
    input  logic [CW-1:0]     c,
    input  logic              ld,
    input  logic              used,
    input  logic [REG_AW-1:0] idx,
    output logic [1:0]        fwd,
    output logic              hazard
);

    // Countdown value maps onto the pipeline stage holding the result
    always_comb begin
        fwd    = FWD_RF;
        hazard = 1'b0;
        if (used && (idx != '0) && (c != '0)) begin
            if (c == CW'(WB_LAT)) begin
                // Producer is in EX/Mem; a load has no data yet
                if (ld) hazard = 1'b1;
                else    fwd    = FWD_EXMEM;
            end else if (c == CW'(WB_LAT - 1)) begin
                fwd = ld ? FWD_MEMWR_LD : FWD_MEMWR_ALU;
            end else if ((c == CW'(1)) && (RF_WR_FIRST != 0)) begin
                // Write-before-read register file covers the Wr stage
                fwd = FWD_RF;
            end else begin
                hazard = 1'b1;
            end
        end
    end

endmodule : operand_classify

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard at the MIPS ID->EX issue point.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   iss_*                   - instruction currently in ID
//   flush                   - branch taken in EX, squash the ID instruction
//   stall                   - hold IF/ID, bubble into ID/EX
//   iss_accept              - ID instruction issues this cycle
//   fwd_a, fwd_b            - EX operand forwarding selects
//   stall_cnt               - saturating count of stalled cycles
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS       = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned WB_LAT      = 3,
    parameter int unsigned RF_WR_FIRST = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rs,
    input  logic [REG_AW-1:0] iss_rt,
    input  logic              iss_use_rs,
    input  logic              iss_use_rt,
    input  logic              iss_wr_en,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_is_load,
    input  logic              flush,
    output logic              stall,
    output logic              iss_accept,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned CW    = $clog2(WB_LAT + 1);
    // Arrays span the full index space so any index reads safely;
    // entries 0 and >= NREGS stay at zero.
    localparam int unsigned DEPTH = 1 << REG_AW;

    logic [CW-1:0] cnt [DEPTH];
    logic          ld  [DEPTH];

    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       haz_a;
    logic       haz_b;
    logic       record;

    operand_classify #(
        .WB_LAT(WB_LAT), .RF_WR_FIRST(RF_WR_FIRST), .CW(CW), .REG_AW(REG_AW)
    ) u_cls_a (
        .c(cnt[iss_rs]), .ld(ld[iss_rs]), .used(iss_use_rs), .idx(iss_rs),
        .fwd(fwd_a_raw), .hazard(haz_a)
    );

    operand_classify #(
        .WB_LAT(WB_LAT), .RF_WR_FIRST(RF_WR_FIRST), .CW(CW), .REG_AW(REG_AW)
    ) u_cls_b (
        .c(cnt[iss_rt]), .ld(ld[iss_rt]), .used(iss_use_rt), .idx(iss_rt),
        .fwd(fwd_b_raw), .hazard(haz_b)
    );

    // Flush dominates: a squashed instruction neither stalls nor issues
    assign stall      = iss_valid & ~flush & (haz_a | haz_b);
    assign iss_accept = iss_valid & ~stall & ~flush;
    assign fwd_a      = iss_accept ? fwd_a_raw : FWD_RF;
    assign fwd_b      = iss_accept ? fwd_b_raw : FWD_RF;
    assign record     = iss_accept & iss_wr_en & (iss_rd != '0);

    // Countdown per register; a new issue overrides the decrement (WAW)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                cnt[r] <= '0;
                ld[r]  <= 1'b0;
            end
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
                if (record && (iss_rd == REG_AW'(r))) begin
                    cnt[r] <= CW'(WB_LAT);
                    ld[r]  <= iss_is_load;
                end
            end
        end
    end

    // Saturating stall performance counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: main instance with default
// parameters, plus a long-latency narrow-counter instance for saturation.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       iss_valid, iss_use_rs, iss_use_rt, iss_wr_en, iss_is_load, flush;
    logic [4:0] iss_rs, iss_rt, iss_rd;
    logic       stall, iss_accept;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    // Saturation instance signals
    logic       s_valid, s_use_rs, s_wr_en;
    logic [4:0] s_rs, s_rd;
    logic       s_stall, s_accept;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic [3:0] s_stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt),
        .iss_wr_en(iss_wr_en), .iss_rd(iss_rd), .iss_is_load(iss_is_load),
        .flush(flush), .stall(stall), .iss_accept(iss_accept),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.WB_LAT(24), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .iss_valid(s_valid), .iss_rs(s_rs), .iss_rt(5'd0),
        .iss_use_rs(s_use_rs), .iss_use_rt(1'b0),
        .iss_wr_en(s_wr_en), .iss_rd(s_rd), .iss_is_load(1'b0),
        .flush(1'b0), .stall(s_stall), .iss_accept(s_accept),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one instruction in ID, then let combinational outputs settle
    task automatic instr(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic wr, input logic [4:0] rd, input logic ld,
                         input logic fl);
        iss_valid = v;  iss_rs = rs; iss_use_rs = urs; iss_rt = rt; iss_use_rt = urt;
        iss_wr_en = wr; iss_rd = rd; iss_is_load = ld; flush = fl;
        #1;
    endtask

    task automatic idle();
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance through the rising edge to the next sampling point
    task automatic step();
        @(negedge clk);
    endtask

    int stall_cycles;
    bit done;

    initial begin
        s_valid = 1'b0; s_use_rs = 1'b0; s_wr_en = 1'b0; s_rs = '0; s_rd = '0;
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 0);
        check("rst_fwd_a", 32'(fwd_a), 0);
        check("rst_fwd_b", 32'(fwd_b), 0);
        check("rst_cnt",   32'(stall_cnt), 0);
        check("rst_accept_idle", 32'(iss_accept), 0);
        reset = 1'b0;

        // add r3,r1,r2 ; add r4,r3,r5 -> EX/Mem forward
        instr(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);
        check("add_r3_accept", 32'(iss_accept), 1);
        step();
        instr(1, 5'd3, 1, 5'd5, 1, 1, 5'd4, 0, 0);
        check("b2b_fwd_a", 32'(fwd_a), 1);
        check("b2b_fwd_b", 32'(fwd_b), 0);
        check("b2b_stall", 32'(stall), 0);
        step();

        // add r12 ; independent ; add r14,r12 -> Mem/Wr ALU forward
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd12, 0, 0); step();
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd13, 0, 0); step();
        instr(1, 5'd12, 1, 5'd0, 1, 1, 5'd14, 0, 0);
        check("gap1_fwd_a", 32'(fwd_a), 2);
        check("gap1_stall", 32'(stall), 0);
        step();

        // lw r2 ; add r6,r2,r2 -> one stall, then load-data forward
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd2, 1, 0); step();
        instr(1, 5'd2, 1, 5'd2, 1, 1, 5'd6, 0, 0);
        check("lu_stall",  32'(stall), 1);
        check("lu_accept", 32'(iss_accept), 0);
        check("lu_fwd_a0", 32'(fwd_a), 0);
        check("lu_fwd_b0", 32'(fwd_b), 0);
        step();
        instr(1, 5'd2, 1, 5'd2, 1, 1, 5'd6, 0, 0);
        check("lu2_stall",  32'(stall), 0);
        check("lu2_accept", 32'(iss_accept), 1);
        check("lu2_fwd_a",  32'(fwd_a), 3);
        check("lu2_fwd_b",  32'(fwd_b), 3);
        check("lu2_cnt",    32'(stall_cnt), 1);
        step();

        // Invalid instruction with a hazard never stalls
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd16, 1, 0); step();
        instr(0, 5'd16, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        check("nv_stall", 32'(stall), 0);
        step();

        // add r0 ; add r7,r0,r0
        instr(1, 5'd1, 1, 5'd1, 1, 1, 5'd0, 0, 0); step();
        instr(1, 5'd0, 1, 5'd0, 1, 1, 5'd7, 0, 0);
        check("r0_stall", 32'(stall), 0);
        check("r0_fwd_a", 32'(fwd_a), 0);
        check("r0_fwd_b", 32'(fwd_b), 0);
        step();

        // Flushed lw r8 is never recorded
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd8, 1, 1);
        check("fl_accept", 32'(iss_accept), 0);
        check("fl_stall",  32'(stall), 0);
        step();
        instr(1, 5'd8, 1, 5'd0, 0, 1, 5'd17, 0, 0);
        check("fl_use_fwd_a", 32'(fwd_a), 0);
        check("fl_use_stall", 32'(stall), 0);
        step();

        // Flush overrides a load-use hazard
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd18, 1, 0); step();
        instr(1, 5'd18, 1, 5'd0, 0, 0, 5'd0, 0, 1);
        check("fl_haz_stall", 32'(stall), 0);
        step();

        // WAW: lw r9 ; add r9 ; read r9 -> ALU producer wins
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 1, 0); step();
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0); step();
        instr(1, 5'd9, 1, 5'd0, 0, 1, 5'd19, 0, 0);
        check("waw_fwd_a", 32'(fwd_a), 1);
        check("waw_stall", 32'(stall), 0);
        step();

        // Producer two cycles back: write-first RF covers it
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd15, 1, 0); step();
        idle(); step();
        idle(); step();
        instr(1, 5'd15, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        check("wrfirst_fwd_a", 32'(fwd_a), 0);
        check("wrfirst_stall", 32'(stall), 0);
        step();

        // add r10 ; reset ; read r10 -> empty scoreboard
        instr(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 0, 0); step();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        instr(1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        check("rst_mid_fwd_a", 32'(fwd_a), 0);
        check("rst_mid_stall", 32'(stall), 0);
        check("rst_mid_cnt",   32'(stall_cnt), 0);
        step();
        idle();

        // Saturation: WB_LAT=24 producer, reader two cycles later stalls
        // while cnt runs 22..2 (21 cycles); 4-bit counter pins at 15.
        s_valid = 1'b1; s_wr_en = 1'b1; s_rd = 5'd1; #1;
        step();
        s_valid = 1'b0; s_wr_en = 1'b0; #1;
        step(); step();
        s_valid = 1'b1; s_use_rs = 1'b1; s_rs = 5'd1; #1;
        check("sat_first_stall", 32'(s_stall), 1);
        stall_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (s_stall) begin
                stall_cycles++;
                step();
            end else begin
                done = 1'b1;
            end
        end
        check("sat_resolved",    32'(done), 1);
        check("sat_stall_len",   32'(stall_cycles), 21);
        check("sat_stall_cnt",   32'(s_stall_cnt), 15);
        check("sat_final_fwd_a", 32'(s_fwd_a), 0);
        check("sat_final_accept",32'(s_accept), 1);
        step();
        s_valid = 1'b0; s_use_rs = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_hazard_scoreboard

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised per-register scoreboard for the 5-stage MIPS pipeline (IF/ID/EX/Mem/Wr). Sits at the ID->EX issue point.
- Tracks in-flight register writes with per-register countdowns and load flags.
- Produces the ID stall, per-operand forwarding selects for the EX operand muxes, and a saturating stall performance counter.
- Honours branch flush from EX: a squashed instruction never enters the scoreboard.

Parameters:
- NREGS, 32, architectural registers; register 0 is hardwired zero and never tracked.
- REG_AW, 5, register index width; must satisfy 2**REG_AW >= NREGS.
- WB_LAT, 3, cycles from issue until the result sits in the register file; must be >= 3.
- RF_WR_FIRST, 1, 1 = register file write is visible to a same-cycle read.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- iss_valid  in  1  instruction present in ID.
- iss_rs  in  REG_AW  source A index.
- iss_rt  in  REG_AW  source B index.
- iss_use_rs  in  1  instruction reads rs.
- iss_use_rt  in  1  instruction reads rt.
- iss_wr_en  in  1  instruction writes a register.
- iss_rd  in  REG_AW  destination index, after the RegDst mux.
- iss_is_load  in  1  instruction is lw.
- flush  in  1  branch taken in EX; squash the ID instruction.
- stall  out  1  hold IF/ID and inject a bubble into ID/EX.
- iss_accept  out  1  iss_valid & ~stall & ~flush.
- fwd_a  out  2  operand A select.
- fwd_b  out  2  operand B select.
- stall_cnt  out  CNT_W  cycles stalled, saturating.

Behaviour:
Interface:
- Single clock, clk. Reset is synchronous and active-high, on port reset.

State:
- Per tracked register r: cnt[r], width clog2(WB_LAT+1), and ld[r].

Update on every rising edge:
- Every cnt[r] > 0 decrements by 1.
- Then, if iss_accept & iss_wr_en & iss_rd != 0: cnt[iss_rd] <= WB_LAT and ld[iss_rd] <= iss_is_load.
- An issue write overrides the decrement of the same entry. The newest producer wins (WAW).

Operand classification (combinational, per used operand with index s != 0, using c = cnt[s]):
- c == 0 -> fwd = 0 (register file).
- c == WB_LAT, ld = 0 -> fwd = 1 (EX/Mem ALUout).
- c == WB_LAT, ld = 1 -> hazard (load-use).
- c == WB_LAT-1, ld = 0 -> fwd = 2 (Mem/Wr ALUout).
- c == WB_LAT-1, ld = 1 -> fwd = 3 (Mem/Wr DataOut).
- c == 1 with RF_WR_FIRST = 1 -> fwd = 0.
- Any other nonzero c -> hazard.

Operand rules:
- An unused operand, or index 0, gives fwd = 0 and no hazard.
- fwd_a and fwd_b are valid whenever iss_accept = 1 and are don't-care otherwise. The implementation drives them to 0 when iss_accept = 0.

Stall and accept:
- stall = iss_valid & ~flush & (hazard_a | hazard_b).
- Flush has priority: flush = 1 forces stall = 0 and iss_accept = 0, and the scoreboard does not record the squashed instruction.
- iss_valid = 0 forces stall = 0.

Latency:
- Stall, forward selects and accept are combinational, available in the same cycle as the ID inputs.
- The scoreboard is visible one cycle after issue.

Stall counter:
- stall_cnt += 1 on each cycle with stall = 1, saturating at all-ones.

Reset:
- All cnt = 0, all ld = 0, stall_cnt = 0.
- Resulting outputs: stall = 0, fwd_a = fwd_b = 0, iss_accept follows the inputs.
- Reset mid-operation discards all in-flight tracking. The next cycle the scoreboard reads as empty.

Decomposition:
- Shared package holds:
  - FWD_RF = 2'd0, FWD_EXMEM = 2'd1, FWD_MEMWR_ALU = 2'd2, FWD_MEMWR_LD = 2'd3.
  - Pipeline stage count constant.
- One sub-module, operand_classify: takes (c, ld, use, idx) and returns (fwd, hazard). It is instantiated twice, once per source operand.

Test Plan:
- Back-to-back add r3 then add r4,r3,r5, WB_LAT=3:
  - second instruction gives fwd_a=1, stall=0.
  - With one independent instruction between them, fwd_a=2.
- lw r2 then add r6,r2,r2:
  - exactly one cycle with stall=1, fwd_a=fwd_b=0 that cycle.
  - next cycle fwd_a=fwd_b=3, iss_accept=1.
  - stall_cnt=1.
- Writes to r0:
  - add r0 issued, then add r7,r0,r0 -> no stall, fwd_a=fwd_b=0.
  - cnt of r0 never set.
- flush=1 while a load to r8 is in ID:
  - iss_accept=0, stall=0.
  - following use of r8 sees fwd_a=0 with no stall.
- WAW:
  - lw r9 then add r9 back-to-back, then a reader of r9 -> fwd_a=1 (ALU producer, not load), no stall.
- Reset asserted one cycle after issuing add r10:
  - cycle after reset: reader of r10 gets fwd_a=0, stall=0, stall_cnt=0.
  - Also check saturation: hold a stall condition 2**CNT_W+2 cycles with CNT_W=4 -> stall_cnt=15.
